// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result valid/ready handshakes of the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, busy);
  modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: one full-adder cell and a registered carry add two WIDTH-bit operands LSB-first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d, out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s, c_next;
  assign s      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_next = (a_sr_q[0] & b_sr_q[0]) | (b_sr_q[0] & carry_q) | (carry_q & a_sr_q[0]);
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE && io.in_valid) begin
      a_sr_d  = io.a;
      b_sr_d  = io.b;
      carry_d = io.cin;
      cnt_d   = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      sum_sr_d = {s, sum_sr_q[WIDTH-1:1]};
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      carry_d  = c_next;
      cnt_d    = cnt_q + 1'b1;
      state_d     = (cnt_q == LAST) ? DONE : ADD;
      out_valid_d = (cnt_q == LAST);
    end else if (state_q == DONE && io.out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end
  // sum and cout come straight from the shift register and carry flop, so they hold through DONE
  assign io.sum       = sum_sr_q;
  assign io.cout      = carry_q;
  assign io.out_valid = out_valid_q;
  assign io.in_ready  = (state_q == IDLE) && !rst;
  assign io.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against an arithmetic model
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int lat;
  logic [W:0] q[$];
  serial_adder_if #(.WIDTH(W)) io ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
    logic [W:0] e;
    int n;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    n = 0;
    while (!io.in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_ready"}, io.in_ready, 1);
    io.a = a; io.b = b; io.cin = c; io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0; io.a = W'($urandom); io.b = W'($urandom); io.cin = 1'($urandom);
    n = 0;
    while (!io.out_valid && n < 50) begin tick(); n++; end
    chk({tag, "_lat"}, n, W);
    chk({tag, "_sum"}, io.sum, e[W-1:0]);
    chk({tag, "_cout"}, io.cout, e[W]);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk({tag, "_drop"}, io.out_valid, 0);
  endtask
  task automatic stream(input int n, input int pv, input int pr, input bit rate, input string tag);
    int rx, cyc, last;
    rx = 0; cyc = 0; last = -1;
    q.delete();
    while (rx < n && cyc < 60000) begin
      io.in_valid = ($urandom_range(99) < pv);
      io.out_ready = ($urandom_range(99) < pr);
      io.a = W'($urandom); io.b = W'($urandom); io.cin = 1'($urandom);
      #1;
      if (io.in_valid && io.in_ready) q.push_back({1'b0, io.a} + {1'b0, io.b} + {{W{1'b0}}, io.cin});
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) chk({tag, "_spurious"}, 1, 0);
        else chk({tag, "_res"}, {io.cout, io.sum}, q.pop_front());
        if (rate && last >= 0) chk({tag, "_ii"}, cyc - last, W + 2);
        last = cyc;
        rx++;
      end
      tick();
      cyc++;
    end
    chk({tag, "_count"}, rx, n);
    io.in_valid = 1'b0; io.out_ready = 1'b1;
    for (int i = 0; i < 30 && io.busy; i++) tick();
    io.out_ready = 1'b0;
  endtask
  initial begin
    logic [W-1:0] hs;
    logic hc;
    io.in_valid = 1'b0; io.out_ready = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0;
    #2;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_sum", io.sum, 0);
    chk("rst_cout", io.cout, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_in_ready", io.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", io.in_ready, 1);
    do_op(8'h5A, 8'h3C, 1'b0, "t1");
    do_op(8'hFF, 8'h01, 1'b0, "t2a");
    do_op(8'hFF, 8'hFF, 1'b1, "t2b");
    io.a = 8'h12; io.b = 8'h34; io.cin = 1'b1; io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    for (int i = 0; i < 30 && !io.out_valid; i++) tick();
    chk("t3_valid", io.out_valid, 1);
    hs = io.sum; hc = io.cout;
    chk("t3_sum", hs, 8'h47);
    io.in_valid = 1'b1; io.a = 8'hAA; io.b = 8'h55; io.cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_sum", io.sum, hs);
      chk("t3_hold_cout", io.cout, hc);
      chk("t3_hold_valid", io.out_valid, 1);
      chk("t3_in_ready", io.in_ready, 0);
    end
    io.out_ready = 1'b1;
    tick();
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    chk("t3_idle_ready", io.in_ready, 1);
    chk("t3_idle_busy", io.busy, 0);
    chk("t3_idle_valid", io.out_valid, 0);
    io.a = 8'hFF; io.b = 8'hFF; io.cin = 1'b1; io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t4_busy_pre", io.busy, 1);
    rst = 1'b1;
    #1;
    chk("t4_out_valid", io.out_valid, 0);
    chk("t4_sum", io.sum, 0);
    chk("t4_busy", io.busy, 0);
    chk("t4_in_ready", io.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    do_op(8'h10, 8'h20, 1'b1, "t4");
    stream(5, 100, 100, 1'b1, "t5");
    stream(1000, 60, 60, 1'b0, "t6");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
